// File: rtl/disp_pkg.sv
// Shared definitions for the display timing generator.
//  - Raster constants for the two standard formats on the HDMI path (720p60, 1080p30).
//  - Pattern mode encodings.
//  - Colour-bar lookup (white, yellow, cyan, green, magenta, red, blue, black).
package disp_pkg;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
  localparam int H720_ACTIVE = 1280;
  localparam int H720_FRONT  = 110;
  localparam int H720_SYNC   = 40;
  localparam int H720_BACK   = 220;
  localparam int V720_ACTIVE = 720;
  localparam int V720_FRONT  = 5;
  localparam int V720_SYNC   = 5;
  localparam int V720_BACK   = 20;

  // 1920x1080 @ 30 Hz (74.25 MHz pixel clock)
  localparam int H1080_ACTIVE = 1920;
  localparam int H1080_FRONT  = 88;
  localparam int H1080_SYNC   = 44;
  localparam int H1080_BACK   = 148;
  localparam int V1080_ACTIVE = 1080;
  localparam int V1080_FRONT  = 4;
  localparam int V1080_SYNC   = 5;
  localparam int V1080_BACK   = 36;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_GRID  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/disp_timing_pgen_if.sv
// Bus between the timing generator, the DDR read FIFO and the DVI encoder.
//  master : the timing generator (drives DataReq, addresses, sync/DE, RGB, status)
//  slave  : the surrounding logic (drives Enable, Mode, Solid_Color, Data, Fifo_Empty)
interface disp_timing_pgen_if #(
  parameter int CNT_W = 12
);
  logic             Enable;
  logic [1:0]       Mode;
  logic [23:0]      Solid_Color;
  logic [23:0]      Data;
  logic             Fifo_Empty;
  logic             DataReq;
  logic [CNT_W-1:0] H_Addr;
  logic [CNT_W-1:0] V_Addr;
  logic             Disp_HS;
  logic             Disp_VS;
  logic             Disp_DE;
  logic [7:0]       Disp_Red;
  logic [7:0]       Disp_Green;
  logic [7:0]       Disp_Blue;
  logic             Frame_Begin;
  logic [15:0]      Underflow_Cnt;

  modport master (
    input  Enable, Mode, Solid_Color, Data, Fifo_Empty,
    output DataReq, H_Addr, V_Addr, Disp_HS, Disp_VS, Disp_DE,
           Disp_Red, Disp_Green, Disp_Blue, Frame_Begin, Underflow_Cnt
  );

  modport slave (
    output Enable, Mode, Solid_Color, Data, Fifo_Empty,
    input  DataReq, H_Addr, V_Addr, Disp_HS, Disp_VS, Disp_DE,
           Disp_Red, Disp_Green, Disp_Blue, Frame_Begin, Underflow_Cnt
  );
endinterface

// File: rtl/disp_pattern_gen.sv
// Combinational test-pattern source.
//  x, y   : active-area coordinates (0-based)
//  mode   : pattern select; passthrough yields 0 (the top muxes in FIFO data)
//  solid  : RGB888 colour for the solid mode
//  rgb    : RGB888 pattern pixel
module disp_pattern_gen
  import disp_pkg::*;
#(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 1280
) (
  input  logic [CNT_W-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  mode_e            mode,
  input  logic [23:0]      solid,
  output logic [23:0]      rgb
);

  logic [CNT_W+2:0] bar_full;
  logic [2:0]       bar_idx;
  logic             on_grid;

  always_comb begin
    // Eight equal bars: bar = x*8/H_ACTIVE. Clamp guards x beyond the active width.
    bar_full = {x, 3'b000} / (CNT_W+3)'(H_ACTIVE);
    bar_idx  = (bar_full > (CNT_W+3)'(7)) ? 3'd7 : bar_full[2:0];
    on_grid  = ((x & CNT_W'(31)) == '0) || ((y & CNT_W'(31)) == '0);
    rgb      = '0;
    case (mode)
      MODE_BARS:  rgb = bar_color(bar_idx);
      MODE_GRID:  rgb = on_grid ? RGB_WHITE : RGB_BLACK;
      MODE_SOLID: rgb = solid;
      default:    rgb = '0;
    endcase
  end

endmodule

// File: rtl/disp_timing_pgen.sv
// Parametrised display timing generator (pixel clock domain).
// Runs H/V raster counters, derives HS/VS/DE, the FIFO read request with
// REQ_LEAD cycles of lead on the internal DE, and the output pixel (FIFO data
// or a built-in pattern). All outputs are registered one cycle after the
// counter state that produced them.
//  Clk, Rst_n : pixel clock, synchronous active-low reset
//  bus        : disp_timing_pgen_if.master (control in, display/status out)
// UF_INIT is the reset value of Underflow_Cnt (0 in normal use; lets
// saturation be reached quickly in simulation).
module disp_timing_pgen
  import disp_pkg::*;
#(
  parameter int          H_ACTIVE = H720_ACTIVE,
  parameter int          H_FRONT  = H720_FRONT,
  parameter int          H_SYNC   = H720_SYNC,
  parameter int          H_BACK   = H720_BACK,
  parameter int          V_ACTIVE = V720_ACTIVE,
  parameter int          V_FRONT  = V720_FRONT,
  parameter int          V_SYNC   = V720_SYNC,
  parameter int          V_BACK   = V720_BACK,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1,
  parameter int          REQ_LEAD = 1,
  parameter int          CNT_W    = 12,
  parameter logic [15:0] UF_INIT  = 16'h0000
) (
  input  logic                Clk,
  input  logic                Rst_n,
  disp_timing_pgen_if.master  bus
);

  localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_DE_START = H_SYNC + H_BACK;
  localparam int V_DE_START = V_SYNC + V_BACK;
  // Request is registered and the FIFO answers one cycle after the read, so the
  // request looks one position further ahead than its lead on internal DE.
  localparam int LOOKAHEAD  = REQ_LEAD + 1;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  mode_e            mode_q, mode_d, mode_eff;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic             req_q, req_d, fb_q, fb_d;
  logic [CNT_W-1:0] haddr_q, haddr_d, vaddr_q, vaddr_d;
  logic [23:0]      rgb_q, rgb_d, pat_rgb;
  logic [15:0]      uf_q, uf_d;

  logic [CNT_W-1:0] x, y, v_ahead;
  logic [CNT_W:0]   h_ahead;
  logic             h_last, v_last, frame_start, de_now;

  function automatic logic h_in_de(input logic [CNT_W-1:0] h);
    return (h >= CNT_W'(H_DE_START)) && (h < CNT_W'(H_DE_START + H_ACTIVE));
  endfunction

  function automatic logic v_in_de(input logic [CNT_W-1:0] v);
    return (v >= CNT_W'(V_DE_START)) && (v < CNT_W'(V_DE_START + V_ACTIVE));
  endfunction

  disp_pattern_gen #(
    .CNT_W    (CNT_W),
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .x     (x),
    .y     (y),
    .mode  (mode_eff),
    .solid (bus.Solid_Color),
    .rgb   (pat_rgb)
  );

  always_comb begin
    h_last      = (h_q == CNT_W'(H_TOTAL - 1));
    v_last      = (v_q == CNT_W'(V_TOTAL - 1));
    frame_start = (h_q == '0) && (v_q == '0);
    // Mode is captured at the first raster position; that pixel already uses it.
    mode_eff    = frame_start ? mode_e'(bus.Mode) : mode_q;
    de_now      = h_in_de(h_q) && v_in_de(v_q);
    x           = h_q - CNT_W'(H_DE_START);
    y           = v_q - CNT_W'(V_DE_START);

    // Raster position LOOKAHEAD cycles ahead, wrapping into the next line.
    h_ahead = {1'b0, h_q} + (CNT_W+1)'(LOOKAHEAD);
    v_ahead = v_q;
    if (h_ahead >= (CNT_W+1)'(H_TOTAL)) begin
      h_ahead = h_ahead - (CNT_W+1)'(H_TOTAL);
      v_ahead = v_last ? '0 : v_q + CNT_W'(1);
    end

    h_d     = '0;
    v_d     = '0;
    mode_d  = mode_q;
    hs_d    = ~HS_POL;
    vs_d    = ~VS_POL;
    de_d    = 1'b0;
    req_d   = 1'b0;
    fb_d    = 1'b0;
    haddr_d = '0;
    vaddr_d = '0;
    rgb_d   = '0;

    if (bus.Enable) begin
      h_d = h_last ? '0 : h_q + CNT_W'(1);
      v_d = v_q;
      if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
      if (frame_start) mode_d = mode_e'(bus.Mode);
      hs_d  = (h_q < CNT_W'(H_SYNC)) ? HS_POL : ~HS_POL;
      vs_d  = (v_q < CNT_W'(V_SYNC)) ? VS_POL : ~VS_POL;
      de_d  = de_now;
      req_d = h_in_de(h_ahead[CNT_W-1:0]) && v_in_de(v_ahead) && (mode_eff == MODE_PASS);
      fb_d  = frame_start;
      if (de_now) begin
        haddr_d = x;
        vaddr_d = y;
        rgb_d   = (mode_eff == MODE_PASS) ? bus.Data : pat_rgb;
      end
    end

    // Counts reads issued against an empty FIFO; the stale Data is still shown.
    uf_d = uf_q;
    if (req_q && bus.Fifo_Empty && (uf_q != 16'hFFFF)) uf_d = uf_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= MODE_PASS;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      fb_q    <= 1'b0;
      haddr_q <= '0;
      vaddr_q <= '0;
      rgb_q   <= '0;
      uf_q    <= UF_INIT;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      req_q   <= req_d;
      fb_q    <= fb_d;
      haddr_q <= haddr_d;
      vaddr_q <= vaddr_d;
      rgb_q   <= rgb_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.DataReq       = req_q;
  assign bus.H_Addr        = haddr_q;
  assign bus.V_Addr        = vaddr_q;
  assign bus.Disp_HS       = hs_q;
  assign bus.Disp_VS       = vs_q;
  assign bus.Disp_DE       = de_q;
  assign bus.Disp_Red      = rgb_q[23:16];
  assign bus.Disp_Green    = rgb_q[15:8];
  assign bus.Disp_Blue     = rgb_q[7:0];
  assign bus.Frame_Begin   = fb_q;
  assign bus.Underflow_Cnt = uf_q;

endmodule

// File: tb/tb_disp_timing_pgen.sv
// Directed bench for disp_timing_pgen.
// DUT A: raster H 8/2/2/2, V 4/1/1/1 (H_TOTAL 14, V_TOTAL 7, 98 cycles/frame).
// DUT B: raster H 16/2/2/2, V 4/1/1/1 (H_TOTAL 22, 154 cycles/frame), Underflow reset value 0xFFF0.
// Frame index i below counts output cycles from the one showing Frame_Begin.
module tb_disp_timing_pgen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  disp_timing_pgen_if #(.CNT_W(12)) ifa ();
  disp_timing_pgen_if #(.CNT_W(12)) ifb ();

  disp_timing_pgen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1), .CNT_W(12), .UF_INIT(16'h0000)
  ) u_dut_a (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifa)
  );

  disp_timing_pgen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1), .CNT_W(12), .UF_INIT(16'hFFF0)
  ) u_dut_b (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (ifb)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model for DUT A: one-cycle read latency, each read presents the next count.
  logic [23:0] fifo_cnt = 24'd0;
  always @(posedge clk) if (ifa.DataReq === 1'b1) fifo_cnt <= fifo_cnt + 24'd1;
  assign ifa.Data = fifo_cnt;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic bit a_de(input int i);
    int h, v;
    h = i % 14;
    v = i / 14;
    return (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fb(input bit sel_b, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      if ((sel_b ? ifb.Frame_Begin : ifa.Frame_Begin) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_frame_begin dut%s: no Frame_Begin in 400 cycles", sel_b ? "B" : "A");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifa.Enable = 1'b1; ifa.Mode = 2'd0; ifa.Solid_Color = 24'h0; ifa.Fifo_Empty = 1'b0;
    ifb.Enable = 1'b1; ifb.Mode = 2'd0; ifb.Solid_Color = 24'h0; ifb.Fifo_Empty = 1'b0;
    ifb.Data = 24'hABCDEF;
    repeat (3) step();
    n_checks++;
    if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq});
    end
    n_checks++;
    if ({ifa.H_Addr, ifa.V_Addr, ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0",
               {ifa.H_Addr, ifa.V_Addr, ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue});
    end
    n_checks++;
    if (ifa.Underflow_Cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_uf_a: got %h expected 0000", ifa.Underflow_Cnt);
    end
    n_checks++;
    if (ifb.Underflow_Cnt !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL reset_uf_b: got %h expected fff0", ifb.Underflow_Cnt);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin} !== 4'b1101) begin
      n_fail++;
      $display("FAIL first_frame_begin: got %b expected 1101",
               {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin});
    end
  endtask

  task automatic test_raster_passthrough();
    bit ok;
    int h, v, de_cnt, req_cnt;
    logic [23:0] exp_px, exp_rgb;
    logic [4:0]  exp_ctrl;
    wait_fb(1'b0, ok);
    if (ok) begin
      de_cnt = 0; req_cnt = 0;
      exp_px = fifo_cnt + 24'd1;
      for (int i = 0; i < 98; i++) begin
        h = i % 14; v = i / 14;
        exp_ctrl = {(h < 2), (v < 1), a_de(i), (i == 0), a_de((i + 2) % 98)};
        n_checks++;
        if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq} !== exp_ctrl) begin
          n_fail++;
          $display("FAIL raster_ctrl i=%0d: got %b expected %b", i,
                   {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq}, exp_ctrl);
        end
        n_checks++;
        if ({ifa.H_Addr, ifa.V_Addr} !== (a_de(i) ? {12'(h - 4), 12'(v - 2)} : 24'h0)) begin
          n_fail++;
          $display("FAIL raster_addr i=%0d: got %0d,%0d", i, ifa.H_Addr, ifa.V_Addr);
        end
        exp_rgb = a_de(i) ? exp_px : 24'h0;
        n_checks++;
        if ({ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue} !== exp_rgb) begin
          n_fail++;
          $display("FAIL passthrough_rgb i=%0d: got %h expected %h", i,
                   {ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue}, exp_rgb);
        end
        if (a_de(i)) exp_px = exp_px + 24'd1;
        if (ifa.Disp_DE === 1'b1) de_cnt++;
        if (ifa.DataReq === 1'b1) req_cnt++;
        step();
      end
      n_checks++;
      if (ifa.Frame_Begin !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_period: Frame_Begin got %b expected 1 after 98 cycles", ifa.Frame_Begin);
      end
      n_checks++;
      if (de_cnt != 32) begin
        n_fail++;
        $display("FAIL de_count: got %0d expected 32", de_cnt);
      end
      n_checks++;
      if (req_cnt != 32) begin
        n_fail++;
        $display("FAIL req_count: got %0d expected 32", req_cnt);
      end
    end
  endtask

  task automatic test_underflow();
    bit ok;
    logic [15:0] start;
    wait_fb(1'b0, ok);
    if (ok) begin
      start = ifa.Underflow_Cnt;
      ifa.Fifo_Empty = 1'b1;
      repeat (98) step();
      ifa.Fifo_Empty = 1'b0;
      repeat (2) step();
      n_checks++;
      if (ifa.Underflow_Cnt !== start + 16'd32) begin
        n_fail++;
        $display("FAIL underflow_frame: got %h expected %h", ifa.Underflow_Cnt, start + 16'd32);
      end
    end
  endtask

  task automatic test_mode_switch();
    bit ok;
    int de_cnt;
    logic [23:0] exp_px, exp_rgb;
    wait_fb(1'b0, ok);
    if (ok) begin
      exp_px = fifo_cnt + 24'd1;
      for (int i = 0; i < 98; i++) begin
        if (i == 40) begin
          ifa.Mode = 2'd3;
          ifa.Solid_Color = 24'h123456;
        end
        exp_rgb = a_de(i) ? exp_px : 24'h0;
        n_checks++;
        if ({ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue} !== exp_rgb) begin
          n_fail++;
          $display("FAIL switch_old_frame i=%0d: got %h expected %h", i,
                   {ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue}, exp_rgb);
        end
        if (a_de(i)) exp_px = exp_px + 24'd1;
        step();
      end
      de_cnt = 0;
      for (int i = 0; i < 98; i++) begin
        exp_rgb = a_de(i) ? 24'h123456 : 24'h0;
        n_checks++;
        if ({ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue, ifa.DataReq} !== {exp_rgb, 1'b0}) begin
          n_fail++;
          $display("FAIL switch_solid i=%0d: got rgb %h req %b expected %h req 0", i,
                   {ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue}, ifa.DataReq, exp_rgb);
        end
        if (ifa.Disp_DE === 1'b1) de_cnt++;
        step();
      end
      n_checks++;
      if (de_cnt != 32) begin
        n_fail++;
        $display("FAIL switch_de_count: got %0d expected 32", de_cnt);
      end
      ifa.Mode = 2'd0;
    end
  endtask

  task automatic test_saturation();
    bit ok;
    wait_fb(1'b1, ok);
    if (ok) begin
      ifb.Fifo_Empty = 1'b1;
      repeat (160) step();
      ifb.Fifo_Empty = 1'b0;
      n_checks++;
      if (ifb.Underflow_Cnt !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL underflow_saturate: got %h expected ffff", ifb.Underflow_Cnt);
      end
      repeat (20) step();
      n_checks++;
      if (ifb.Underflow_Cnt !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL underflow_hold: got %h expected ffff", ifb.Underflow_Cnt);
      end
    end
  endtask

  task automatic test_bars();
    bit ok, de;
    int h, v;
    logic [23:0] exp_rgb;
    ifb.Mode = 2'd1;
    wait_fb(1'b1, ok);
    if (ok) begin
      for (int i = 0; i < 154; i++) begin
        h = i % 22; v = i / 22;
        de = (h >= 4) && (h < 20) && (v >= 2) && (v < 6);
        exp_rgb = de ? bars[(h - 4) / 2] : 24'h0;
        n_checks++;
        if ({ifb.Disp_DE, ifb.DataReq, ifb.Disp_Red, ifb.Disp_Green, ifb.Disp_Blue} !== {de, 1'b0, exp_rgb}) begin
          n_fail++;
          $display("FAIL bars i=%0d: got de %b req %b rgb %h expected de %b req 0 rgb %h", i,
                   ifb.Disp_DE, ifb.DataReq, {ifb.Disp_Red, ifb.Disp_Green, ifb.Disp_Blue}, de, exp_rgb);
        end
        step();
      end
    end
    ifb.Mode = 2'd0;
  endtask

  task automatic test_reset_midline();
    bit ok;
    wait_fb(1'b0, ok);
    if (ok) begin
      repeat (35) step();
      n_checks++;
      if (ifa.Disp_DE !== 1'b1) begin
        n_fail++;
        $display("FAIL midline_de: got %b expected 1", ifa.Disp_DE);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_checks++;
      if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq, ifa.H_Addr,
           ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue, ifa.Underflow_Cnt} !== 57'h0) begin
        n_fail++;
        $display("FAIL midline_reset: got ctrl %b haddr %0d rgb %h uf %h expected all 0",
                 {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq}, ifa.H_Addr,
                 {ifa.Disp_Red, ifa.Disp_Green, ifa.Disp_Blue}, ifa.Underflow_Cnt);
      end
      step();
      n_checks++;
      if (ifa.Frame_Begin !== 1'b1) begin
        n_fail++;
        $display("FAIL restart_after_reset: Frame_Begin got %b expected 1", ifa.Frame_Begin);
      end
      ifa.Enable = 1'b0;
      repeat (4) step();
      n_checks++;
      if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq} !== 5'b00000) begin
        n_fail++;
        $display("FAIL enable_low: got %b expected 00000",
                 {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin, ifa.DataReq});
      end
      ifa.Enable = 1'b1;
      step();
      n_checks++;
      if ({ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin} !== 4'b1101) begin
        n_fail++;
        $display("FAIL enable_restart: got %b expected 1101",
                 {ifa.Disp_HS, ifa.Disp_VS, ifa.Disp_DE, ifa.Frame_Begin});
      end
      repeat (97) step();
      n_checks++;
      if (ifa.Frame_Begin !== 1'b0) begin
        n_fail++;
        $display("FAIL restart_no_early_fb: got %b expected 0", ifa.Frame_Begin);
      end
      step();
      n_checks++;
      if (ifa.Frame_Begin !== 1'b1) begin
        n_fail++;
        $display("FAIL restart_period: got %b expected 1", ifa.Frame_Begin);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raster_passthrough();
    test_underflow();
    test_mode_switch();
    test_saturation();
    test_bars();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
